// File: rtl/barrido_displays_if.sv
// Signal bundle between the decoder stage and the 4-digit scan controller.
interface barrido_displays_if;
    logic       en;
    logic [7:0] catodo1;
    logic [7:0] catodo2;
    logic [7:0] catodo3;
    logic [7:0] catodo4;
    logic [3:0] anodo;
    logic [7:0] catodo;
    logic       frame_start;

    modport master (
        output en, catodo1, catodo2, catodo3, catodo4,
        input  anodo, catodo, frame_start
    );

    modport slave (
        input  en, catodo1, catodo2, catodo3, catodo4,
        output anodo, catodo, frame_start
    );
endinterface

// File: rtl/barrido_displays.sv
// Time-multiplexed 4-digit seven-segment scan with per-slot blanking and
// once-per-frame input snapshot so a displayed frame is never torn.
module barrido_displays #(
    parameter int unsigned DIV  = 50000,
    parameter int unsigned DEAD = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    barrido_displays_if.slave  bus
);
    localparam int unsigned CW = $clog2(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("barrido_displays: DIV must be >= 2");
    end
    if (DEAD >= DIV) begin : g_bad_dead
        $error("barrido_displays: DEAD must be < DIV");
    end

    logic [CW-1:0]   cnt,      cnt_nxt;
    logic [1:0]      dig,      dig_nxt;
    logic [3:0][7:0] shadow,   shadow_nxt;
    logic [3:0]      anodo_q,  anodo_nxt;
    logic [7:0]      catodo_q, catodo_nxt;
    logic            fs_q,     fs_nxt;
    logic            snap;

    // Next state: slot/digit advance, frame snapshot and phase decode.
    always_comb begin
        cnt_nxt    = cnt;
        dig_nxt    = dig;
        shadow_nxt = shadow;
        anodo_nxt  = 4'hF;
        catodo_nxt = 8'hFF;
        fs_nxt     = 1'b0;
        snap       = 1'b0;
        if (bus.en) begin
            snap = (cnt == '0) && (dig == 2'd0);
            if (snap) begin
                shadow_nxt = {bus.catodo4, bus.catodo3, bus.catodo2, bus.catodo1};
            end
            fs_nxt = snap;
            if (cnt == CW'(DIV - 1)) begin
                cnt_nxt = '0;
                dig_nxt = dig + 2'd1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
            // Drive from the freshly written shadow so DEAD=0 shows new data immediately.
            if (cnt >= CW'(DEAD)) begin
                anodo_nxt  = ~(4'b0001 << dig);
                catodo_nxt = shadow_nxt[dig];
            end
        end else begin
            cnt_nxt = '0;
            dig_nxt = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            dig      <= 2'd0;
            shadow   <= {4{8'hFF}};
            anodo_q  <= 4'hF;
            catodo_q <= 8'hFF;
            fs_q     <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            dig      <= dig_nxt;
            shadow   <= shadow_nxt;
            anodo_q  <= anodo_nxt;
            catodo_q <= catodo_nxt;
            fs_q     <= fs_nxt;
        end
    end

    assign bus.anodo       = anodo_q;
    assign bus.catodo      = catodo_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_barrido_displays.sv
// Bench for barrido_displays: directed table/sequence checks plus random
// stimulus against a frame-position reference model.
module tb_barrido_displays;
    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic rst_n;
    barrido_displays_if bus ();

    barrido_displays #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: position within the frame, snapshot array, expected outputs.
    int         m_pos = 0;
    logic [7:0] m_sh [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [3:0] e_an = 4'hF;
    logic [7:0] e_ca = 8'hFF;
    logic       e_fs = 1'b0;

    always @(posedge clk) begin
        int slot, off;
        if (!rst_n) begin
            m_pos = 0;
            for (int k = 0; k < 4; k++) m_sh[k] = 8'hFF;
            e_an = 4'hF; e_ca = 8'hFF; e_fs = 1'b0;
        end else if (!bus.en) begin
            m_pos = 0;
            e_an = 4'hF; e_ca = 8'hFF; e_fs = 1'b0;
        end else begin
            e_fs = (m_pos == 0);
            if (m_pos == 0) m_sh = '{bus.catodo1, bus.catodo2, bus.catodo3, bus.catodo4};
            slot = m_pos / DIV;
            off  = m_pos % DIV;
            if (off < DEAD) begin
                e_an = 4'hF; e_ca = 8'hFF;
            end else begin
                e_an = 4'hF ^ (4'(1) << slot);
                e_ca = m_sh[slot];
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    end

    // Every-cycle comparison against the model plus display invariants.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_anodo", 8'(bus.anodo), 8'(e_an));
            chk("model_catodo", bus.catodo, e_ca);
            chk("model_frame_start", 8'(bus.frame_start), 8'(e_fs));
            chk("inv_onehot", 8'($countones(~bus.anodo) <= 1), 8'd1);
            if (bus.anodo == 4'hF) chk("inv_blank_cat", bus.catodo, 8'hFF);
        end
    end

    logic [3:0] cap_an [64];
    logic [7:0] cap_ca [64];
    logic       cap_fs [64];

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cap_an[i] = bus.anodo;
            cap_ca[i] = bus.catodo;
            cap_fs[i] = bus.frame_start;
        end
    endtask

    task automatic chk_cap(input string nm, input int i, input logic [3:0] an,
                           input logic [7:0] ca, input logic fs);
        chk({nm, "_an"}, 8'(cap_an[i]), 8'(an));
        chk({nm, "_ca"}, cap_ca[i], ca);
        chk({nm, "_fs"}, 8'(cap_fs[i]), 8'(fs));
    endtask

    task automatic set_cat(input logic [7:0] a, b, c, d);
        bus.catodo1 = a; bus.catodo2 = b; bus.catodo3 = c; bus.catodo4 = d;
    endtask

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] ca;
        logic       fs;
    } vec_t;

    vec_t tbl [12];
    logic [7:0] r1, r2, r3, r4;

    initial begin
        tbl[0]  = '{0,  4'hF, 8'hFF, 1'b1};
        tbl[1]  = '{1,  4'hF, 8'hFF, 1'b0};
        tbl[2]  = '{2,  4'hE, 8'hC0, 1'b0};
        tbl[3]  = '{7,  4'hE, 8'hC0, 1'b0};
        tbl[4]  = '{8,  4'hF, 8'hFF, 1'b0};
        tbl[5]  = '{10, 4'hD, 8'hF9, 1'b0};
        tbl[6]  = '{18, 4'hB, 8'hA4, 1'b0};
        tbl[7]  = '{26, 4'h7, 8'hB0, 1'b0};
        tbl[8]  = '{31, 4'h7, 8'hB0, 1'b0};
        tbl[9]  = '{32, 4'hF, 8'hFF, 1'b1};
        tbl[10] = '{34, 4'hE, 8'hC0, 1'b0};
        tbl[11] = '{39, 4'hE, 8'hC0, 1'b0};

        // Reset held for 3 clocks with en high.
        rst_n = 1'b0;
        bus.en = 1'b1;
        set_cat(8'hC0, 8'hF9, 8'hA4, 8'hB0);
        step(1);
        chk_on = 1'b1;
        step(2);
        chk("reset_anodo", 8'(bus.anodo), 8'h0F);
        chk("reset_catodo", bus.catodo, 8'hFF);
        chk("reset_fs", 8'(bus.frame_start), 8'h00);

        // Basic scan, compared against the vector table.
        rst_n = 1'b1;
        capture(40);
        foreach (tbl[i]) chk_cap($sformatf("scan_c%0d", tbl[i].cyc), tbl[i].cyc,
                                 tbl[i].an, tbl[i].ca, tbl[i].fs);

        // Inputs change during digit-2 slot; current frame must stay coherent.
        step(10);
        set_cat(8'h99, 8'h99, 8'h99, 8'h99);
        capture(48);
        chk_cap("coh_d2_old", 0, 4'hB, 8'hA4, 1'b0);
        chk_cap("coh_d3_old", 8, 4'h7, 8'hB0, 1'b0);
        chk_cap("coh_fs", 14, 4'hF, 8'hFF, 1'b1);
        chk_cap("coh_d0_new", 16, 4'hE, 8'h99, 1'b0);
        chk_cap("coh_d1_new", 24, 4'hD, 8'h99, 1'b0);
        chk_cap("coh_d3_new", 40, 4'h7, 8'h99, 1'b0);

        // Drop en mid digit-1 slot, then restart with a fresh snapshot.
        step(10);
        bus.en = 1'b0;
        capture(3);
        chk_cap("en_off0", 0, 4'hF, 8'hFF, 1'b0);
        chk_cap("en_off2", 2, 4'hF, 8'hFF, 1'b0);
        r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom); r4 = 8'($urandom);
        set_cat(r1, r2, r3, r4);
        bus.en = 1'b1;
        capture(12);
        chk_cap("en_on_fs", 0, 4'hF, 8'hFF, 1'b1);
        chk_cap("en_on_d0", 2, 4'hE, r1, 1'b0);
        chk_cap("en_on_d1", 10, 4'hD, r2, 1'b0);

        // Reset during digit-3 drive.
        step(15);
        rst_n = 1'b0;
        capture(2);
        chk_cap("rst_mid0", 0, 4'hF, 8'hFF, 1'b0);
        chk_cap("rst_mid1", 1, 4'hF, 8'hFF, 1'b0);
        rst_n = 1'b1;
        capture(4);
        chk_cap("rst_rel_fs", 0, 4'hF, 8'hFF, 1'b1);
        chk_cap("rst_rel_d0", 2, 4'hE, r1, 1'b0);

        // Random enable, reset and input activity against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.en = ($urandom_range(0, 99) < 97);
            rst_n  = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) == 0)
                set_cat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        bus.en = 1'b1;
        rst_n  = 1'b1;
        step(40);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
